// File: rtl/approx_mul_err_sweep.sv
// approx_mul_err_sweep: drives all 2^(2N) operand pairs into an external multiplier and accumulates sum |err|, error count and worst error with its first operands; ports clk/rst/start in, mult_a/mult_b out, approx_p in, busy/done/statistics out
module approx_mul_err_sweep #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     mult_a,
  output logic [N-1:0]     mult_b,
  input  logic [2*N-1:0]   approx_p,
  output logic             busy,
  output logic             done,
  output logic [4*N-1:0]   sum_abs_err,
  output logic [2*N:0]     err_cnt,
  output logic [2*N-1:0]   max_err,
  output logic [N-1:0]     max_a,
  output logic [N-1:0]     max_b
);
  localparam int W = 2 * N;
  localparam int S = 4 * N;
  localparam int C = W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic           done_q, done_d, v1_q, clr;
  logic [W-1:0]   ap1_q, ex1_q, ex_d, err_d;
  logic [N-1:0]   a1_q, b1_q;
  logic [S-1:0]   sum_q;
  logic [C-1:0]   cnt_q;
  logic [W-1:0]   max_q;
  logic [N-1:0]   maxa_q, maxb_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start ? RUN : IDLE;
        idx_d   = start ? '0 : idx_q;
      end
      RUN: begin
        idx_d   = idx_q + 1'b1;
        state_d = &idx_q ? DRAIN : RUN;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign clr   = state_q == IDLE && start;
  assign ex_d  = W'(mult_a) * W'(mult_b);
  assign err_d = ap1_q >= ex1_q ? ap1_q - ex1_q : ex1_q - ap1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      ap1_q   <= '0;
      ex1_q   <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      maxa_q  <= '0;
      maxb_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      v1_q    <= state_q == RUN;
      ap1_q   <= approx_p;
      ex1_q   <= ex_d;
      a1_q    <= mult_a;
      b1_q    <= mult_b;
      if (clr) begin
        sum_q  <= '0;
        cnt_q  <= '0;
        max_q  <= '0;
        maxa_q <= '0;
        maxb_q <= '0;
      end else if (v1_q) begin
        sum_q <= sum_q + S'(err_d);
        cnt_q <= cnt_q + C'(err_d != '0);
        if (err_d > max_q) begin
          max_q  <= err_d;
          maxa_q <= a1_q;
          maxb_q <= b1_q;
        end
      end
    end
  end
  assign mult_a      = idx_q[W-1:N];
  assign mult_b      = idx_q[N-1:0];
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign sum_abs_err = sum_q;
  assign err_cnt     = cnt_q;
  assign max_err     = max_q;
  assign max_a       = maxa_q;
  assign max_b       = maxb_q;
endmodule

// File: tb/tb_approx_mul_err_sweep.sv
// tb_approx_mul_err_sweep: randomized and directed sweeps of three DUT widths against an exhaustive software model
module tb_approx_mul_err_sweep;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] st, rs;
  int mode[3];
  logic [7:0] tbl[256];
  logic [31:0] o_sum[3];
  logic [16:0] o_cnt[3];
  logic [15:0] o_mx[3];
  logic [7:0]  o_xa[3], o_xb[3], o_ma[3], o_mb[3];
  logic        o_bz[3], o_dn[3];
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic [15:0] approx_fn(int m, int n, logic [7:0] a, logic [7:0] b, logic [7:0] t);
    logic [15:0] p, r;
    p = 16'(a) * 16'(b);
    r = m == 0 ? p : m == 1 ? 16'd0 : m == 2 ? p ^ 16'd1 : m == 3 ? p + 16'd3 : p ^ {10'd0, t[5:0]};
    return r & 16'((32'd1 << (2 * n)) - 32'd1);
  endfunction
  function automatic int nw(int g);
    return g == 0 ? 2 : g == 1 ? 4 : 8;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int NN = g == 0 ? 2 : g == 1 ? 4 : 8;
    localparam int WW = 2 * NN;
    logic [NN-1:0]   ma, mb, xa, xb;
    logic [WW-1:0]   ap, mx;
    logic [4*NN-1:0] sm;
    logic [WW:0]     ct;
    logic            bz, dn;
    assign ap = WW'(approx_fn(mode[g], NN, 8'(ma), 8'(mb), tbl[{4'(ma), 4'(mb)}]));
    approx_mul_err_sweep #(.N(NN)) dut (
      .clk(clk), .rst(rs[g]), .start(st[g]), .mult_a(ma), .mult_b(mb), .approx_p(ap),
      .busy(bz), .done(dn), .sum_abs_err(sm), .err_cnt(ct), .max_err(mx), .max_a(xa), .max_b(xb)
    );
    assign o_sum[g] = 32'(sm);
    assign o_cnt[g] = 17'(ct);
    assign o_mx[g]  = 16'(mx);
    assign o_xa[g]  = 8'(xa);
    assign o_xb[g]  = 8'(xb);
    assign o_ma[g]  = 8'(ma);
    assign o_mb[g]  = 8'(mb);
    assign o_bz[g]  = bz;
    assign o_dn[g]  = dn;
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model(input int g, output longint s, output longint c, output longint mx, output longint xa, output longint xb);
    int n = nw(g);
    longint p, q, d;
    s = 0; c = 0; mx = 0; xa = 0; xb = 0;
    for (int a = 0; a < (1 << n); a++)
      for (int b = 0; b < (1 << n); b++) begin
        p = a * b;
        q = approx_fn(mode[g], n, 8'(a), 8'(b), tbl[{4'(a), 4'(b)}]);
        d = q > p ? q - p : p - q;
        s += d;
        if (d != 0) c++;
        if (d > mx) begin mx = d; xa = a; xb = b; end
      end
  endtask
  task automatic chk_stats(input int g);
    longint s, c, mx, xa, xb;
    model(g, s, c, mx, xa, xb);
    chk("sum_abs_err", o_sum[g], s);
    chk("err_cnt", o_cnt[g], c);
    chk("max_err", o_mx[g], mx);
    chk("max_a", o_xa[g], xa);
    chk("max_b", o_xb[g], xb);
  endtask
  task automatic lit(input int g, input longint s, input longint c, input longint mx, input longint xa, input longint xb);
    chk("lit_sum", o_sum[g], s);
    chk("lit_cnt", o_cnt[g], c);
    chk("lit_max", o_mx[g], mx);
    chk("lit_max_a", o_xa[g], xa);
    chk("lit_max_b", o_xb[g], xb);
  endtask
  task automatic zero_chk(input int g);
    chk("z_busy", o_bz[g], 0);
    chk("z_done", o_dn[g], 0);
    chk("z_mult_a", o_ma[g], 0);
    chk("z_mult_b", o_mb[g], 0);
    lit(g, 0, 0, 0, 0, 0);
  endtask
  task automatic wait_done(input int g, input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_dn[g] && cyc < bound);
    if (!o_dn[g]) chk("done_timeout", 0, 1);
  endtask
  task automatic sweep(input int g, input int pulse_at);
    int n = nw(g);
    int p = 1 << (2 * n);
    int cyc = 0;
    bit got = 0;
    @(negedge clk);
    st[g] = 1'b1;
    while (!got && cyc < p + 8) begin
      @(negedge clk);
      cyc++;
      st[g] = cyc == pulse_at;
      if (o_dn[g]) begin
        got = 1;
        chk("done_time", cyc - 1, p + 1);
      end else begin
        chk("busy", o_bz[g], 1);
        if (cyc - 1 < p) begin
          chk("op_a", o_ma[g], (cyc - 1) >> n);
          chk("op_b", o_mb[g], (cyc - 1) & ((1 << n) - 1));
        end
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    chk("busy_at_done", o_bz[g], 0);
    chk_stats(g);
    @(negedge clk);
    chk("done_pulse", o_dn[g], 0);
    chk_stats(g);
  endtask
  initial begin
    int cyc, nd;
    st = '0;
    rs = '1;
    mode = '{0, 0, 0};
    for (int i = 0; i < 256; i++) tbl[i] = $urandom_range(0, 1) ? 8'($urandom) : 8'd0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) zero_chk(g);
    rs = '0;
    mode[0] = 0; sweep(0, 0); lit(0, 0, 0, 0, 0, 0);
    mode[0] = 2; sweep(0, 0); lit(0, 16, 16, 1, 0, 0);
    mode[0] = 3; sweep(0, 0); lit(0, 48, 16, 3, 0, 0);
    mode[0] = 1; sweep(0, 0);
    mode[0] = 4; sweep(0, 0);
    mode[1] = 4;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) tbl[i] = $urandom_range(0, 2) != 0 ? 8'($urandom) : 8'd0;
      sweep(1, 0);
    end
    sweep(1, 100);
    st[1] = 1'b1;
    wait_done(1, 300, cyc);
    chk("held_done_time", cyc, 258);
    chk_stats(1);
    @(negedge clk);
    chk("held_restart_busy", o_bz[1], 1);
    chk("held_restart_done", o_dn[1], 0);
    chk("held_restart_sum", o_sum[1], 0);
    chk("held_restart_cnt", o_cnt[1], 0);
    chk("held_restart_a", o_ma[1], 0);
    st[1] = 1'b0;
    wait_done(1, 300, cyc);
    chk("held_done_time2", cyc, 257);
    chk_stats(1);
    @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre_rst_busy", o_bz[1], 1);
    rs[1] = 1'b1;
    @(negedge clk);
    rs[1] = 1'b0;
    zero_chk(1);
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_dn[1] || o_bz[1]) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    sweep(1, 0);
    mode[2] = 1;
    sweep(2, 0);
    lit(2, 1065369600, 65025, 65025, 255, 255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
